// File: rtl/ft_spi_slave_if.sv
// rtl/ft_spi_slave_if.sv - FT2232 host SPI pins (host = master, responder = slave).
interface ft_spi_slave_if;
  logic i_sck;
  logic i_mosi;
  logic i_cs_n;
  logic o_miso;

  modport master (output i_sck, output i_mosi, output i_cs_n, input o_miso);
  modport slave  (input i_sck, input i_mosi, input i_cs_n, output o_miso);
endinterface

// File: rtl/ft_spi_slave.sv
// rtl/ft_spi_slave.sv - oversampling mode-0 SPI responder for the FT2232 host link.
// Optional FT_SPI_BYTECNT_EN adds o_byte_count (received words in the current frame).
module ft_spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ft_spi_slave_if.slave     spi,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_next,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_frame_start,
  output logic              o_frame_end,
  output logic              o_frame_err,
`ifdef FT_SPI_BYTECNT_EN
  output logic [15:0]       o_byte_count,
`endif
  output logic              o_busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]  vld_q, vld_d;
  logic                    sck_d1_q, sck_d1_d;
  logic                    cs_d1_q, cs_d1_d;
  logic                    armed_q, armed_d;
  logic [DATA_W-1:0]       tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]       rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]       rx_data_q, rx_data_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    skip_fall_q, skip_fall_d;
  logic                    tx_next_q, tx_next_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    frame_start_q, frame_start_d;
  logic                    frame_end_q, frame_end_d;
  logic                    frame_err_q, frame_err_d;
`ifdef FT_SPI_BYTECNT_EN
  logic [15:0]             byte_cnt_q, byte_cnt_d;
`endif

  logic              sck_s, mosi_s, cs_s;
  logic              sck_rise, sck_fall, cs_fall, cs_rise;
  logic [DATA_W-1:0] rx_word;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d1_q;
  assign sck_fall = ~sck_s & sck_d1_q;
  // armed_q blocks a frame start until CS has really been seen high since reset
  assign cs_fall  = armed_q & cs_d1_q & ~cs_s;
  assign cs_rise  = cs_s & ~cs_d1_q;
  assign rx_word  = {rx_shift_q[DATA_W-2:0], mosi_s};

  always_comb begin
    state_d       = state_q;
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], spi.i_sck};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], spi.i_mosi};
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], spi.i_cs_n};
    vld_d         = {vld_q[SYNC_STAGES-2:0], 1'b1};
    sck_d1_d      = sck_s;
    cs_d1_d       = cs_s;
    armed_d       = armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    bit_cnt_d     = bit_cnt_q;
    skip_fall_d   = skip_fall_q;
    tx_next_d     = 1'b0;
    rx_valid_d    = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_err_d   = 1'b0;
`ifdef FT_SPI_BYTECNT_EN
    byte_cnt_d    = byte_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          tx_shift_d    = i_tx_data;
          tx_next_d     = 1'b1;
          frame_start_d = 1'b1;
          bit_cnt_d     = '0;
          skip_fall_d   = 1'b0;
          state_d       = ACTIVE;
`ifdef FT_SPI_BYTECNT_EN
          byte_cnt_d    = 16'd0;
`endif
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          frame_end_d = 1'b1;
          frame_err_d = (bit_cnt_q != '0);
          state_d     = IDLE;
        end else if (sck_rise) begin
          rx_shift_d = rx_word;
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d   = rx_word;
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            tx_shift_d  = i_tx_data;
            tx_next_d   = 1'b1;
            skip_fall_d = 1'b1;
`ifdef FT_SPI_BYTECNT_EN
            if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          // the fall right after a reload must keep the fresh MSB on MISO
          if (skip_fall_q) skip_fall_d = 1'b0;
          else             tx_shift_d  = tx_shift_q << 1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sck_sync_q    <= '0;
      mosi_sync_q   <= '0;
      cs_sync_q     <= '1;
      vld_q         <= '0;
      sck_d1_q      <= 1'b0;
      cs_d1_q       <= 1'b1;
      armed_q       <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      bit_cnt_q     <= '0;
      skip_fall_q   <= 1'b0;
      tx_next_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef FT_SPI_BYTECNT_EN
      byte_cnt_q    <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      cs_sync_q     <= cs_sync_d;
      vld_q         <= vld_d;
      sck_d1_q      <= sck_d1_d;
      cs_d1_q       <= cs_d1_d;
      armed_q       <= armed_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      bit_cnt_q     <= bit_cnt_d;
      skip_fall_q   <= skip_fall_d;
      tx_next_q     <= tx_next_d;
      rx_valid_q    <= rx_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_err_q   <= frame_err_d;
`ifdef FT_SPI_BYTECNT_EN
      byte_cnt_q    <= byte_cnt_d;
`endif
    end
  end

  assign spi.o_miso    = (state_q == ACTIVE) & tx_shift_q[DATA_W-1];
  assign o_busy        = (state_q == ACTIVE);
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_tx_next     = tx_next_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_end   = frame_end_q;
  assign o_frame_err   = frame_err_q;
`ifdef FT_SPI_BYTECNT_EN
  assign o_byte_count  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_ft_spi_slave.sv
// tb/tb_ft_spi_slave.sv - directed bench for ft_spi_slave (SCK = clk/8, host driven on negedge clk).
module tb_ft_spi_slave;
  localparam int SYNC = 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_next, rx_valid, frame_start, frame_end, frame_err, busy;
  logic [7:0] rx_data;
`ifdef FT_SPI_BYTECNT_EN
  logic [15:0] byte_count;
`endif

  ft_spi_slave_if spi_if ();

  ft_spi_slave #(.DATA_W(8), .SYNC_STAGES(SYNC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi           (spi_if),
    .i_tx_data     (tx_data),
    .o_tx_next     (tx_next),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .o_frame_start (frame_start),
    .o_frame_end   (frame_end),
    .o_frame_err   (frame_err),
`ifdef FT_SPI_BYTECNT_EN
    .o_byte_count  (byte_count),
`endif
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // pulse counters and receive log, written only by the monitor
  int         n_rx = 0, n_txn = 0, n_start = 0, n_end = 0, n_err = 0, n_err_end = 0;
  logic [7:0] rx_log [0:63];
  int         s_rx, s_txn, s_start, s_end, s_err, s_err_end;

  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (n_rx < 64) rx_log[n_rx] = rx_data;
        n_rx++;
      end
      if (tx_next)     n_txn++;
      if (frame_start) n_start++;
      if (frame_end)   n_end++;
      if (frame_err)   n_err++;
      if (frame_err && frame_end) n_err_end++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_rx = n_rx; s_txn = n_txn; s_start = n_start;
    s_end = n_end; s_err = n_err; s_err_end = n_err_end;
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0: MOSI set on the fall, MISO sampled by the host at the rise
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_if.i_mosi = tx[7-i];
      clks(4);
      spi_if.i_sck = 1'b1;
      rx[7-i] = spi_if.o_miso;
      clks(4);
      spi_if.i_sck = 1'b0;
    end
  endtask

  task automatic frame_1byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_if.i_cs_n = 1'b0;
    clks(4);
    spi_xfer(tx, 8, rx);
    clks(4);
    spi_if.i_cs_n = 1'b1;
  endtask

  logic [7:0] m0, m1, m2, m3;
  logic       noise_bad;

  initial begin
    rst_n = 1'b0;
    spi_if.i_sck = 1'b0; spi_if.i_mosi = 1'b0; spi_if.i_cs_n = 1'b1;
    tx_data = 8'h00;
    clks(3);
    rst_n = 1'b1;
    clks(6);

    check("reset_miso", 32'(spi_if.o_miso), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pulses", 32'(n_rx + n_txn + n_start + n_end + n_err), 32'd0);
`ifdef FT_SPI_BYTECNT_EN
    check("reset_byte_count", 32'(byte_count), 32'd0);
`endif

    // single byte
    snap();
    tx_data = 8'h3C;
    spi_if.i_cs_n = 1'b0;
    clks(4);
    check("single_busy", 32'(busy), 32'd1);
    spi_xfer(8'hA5, 8, m0);
    clks(4);
    spi_if.i_cs_n = 1'b1;
    clks(6);
    check("single_miso", 32'(m0), 32'h3C);
    check("single_rx_valid_cnt", 32'(n_rx - s_rx), 32'd1);
    check("single_rx_data", 32'(rx_data), 32'hA5);
    check("single_tx_next_cnt", 32'(n_txn - s_txn), 32'd2);
    check("single_start_cnt", 32'(n_start - s_start), 32'd1);
    check("single_end_cnt", 32'(n_end - s_end), 32'd1);
    check("single_err_cnt", 32'(n_err - s_err), 32'd0);
    check("single_busy_after", 32'(busy), 32'd0);

    // burst of four words in one frame
    snap();
    tx_data = 8'h10;
    spi_if.i_cs_n = 1'b0;
    clks(4);
    tx_data = 8'h20;
    spi_xfer(8'h01, 8, m0); tx_data = 8'h30;
    spi_xfer(8'h02, 8, m1); tx_data = 8'h40;
    spi_xfer(8'h03, 8, m2); tx_data = 8'h00;
    spi_xfer(8'h04, 8, m3);
    clks(4);
`ifdef FT_SPI_BYTECNT_EN
    check("burst_byte_count", 32'(byte_count), 32'd4);
`endif
    spi_if.i_cs_n = 1'b1;
    clks(6);
    check("burst_miso0", 32'(m0), 32'h10);
    check("burst_miso1", 32'(m1), 32'h20);
    check("burst_miso2", 32'(m2), 32'h30);
    check("burst_miso3", 32'(m3), 32'h40);
    check("burst_rx_valid_cnt", 32'(n_rx - s_rx), 32'd4);
    check("burst_rx0", 32'(rx_log[s_rx]), 32'h01);
    check("burst_rx1", 32'(rx_log[s_rx+1]), 32'h02);
    check("burst_rx2", 32'(rx_log[s_rx+2]), 32'h03);
    check("burst_rx3", 32'(rx_log[s_rx+3]), 32'h04);
    check("burst_err_cnt", 32'(n_err - s_err), 32'd0);
`ifdef FT_SPI_BYTECNT_EN
    check("burst_byte_count_held", 32'(byte_count), 32'd4);
`endif

    // abort after 5 SCK rises
    snap();
    spi_if.i_cs_n = 1'b0;
    clks(4);
    spi_xfer(8'hB7, 5, m0);
    clks(4);
    spi_if.i_cs_n = 1'b1;
    clks(6);
    check("abort_err_cnt", 32'(n_err - s_err), 32'd1);
    check("abort_end_cnt", 32'(n_end - s_end), 32'd1);
    check("abort_err_with_end", 32'(n_err_end - s_err_end), 32'd1);
    check("abort_no_rx_valid", 32'(n_rx - s_rx), 32'd0);
    check("abort_rx_data_held", 32'(rx_data), 32'h04);
    snap();
    tx_data = 8'h00;
    frame_1byte(8'hFF, m0);
    clks(6);
    check("after_abort_rx_data", 32'(rx_data), 32'hFF);
    check("after_abort_rx_cnt", 32'(n_rx - s_rx), 32'd1);
    check("after_abort_err_cnt", 32'(n_err - s_err), 32'd0);

    // reset mid-frame, CS held low across the release
    spi_if.i_cs_n = 1'b0;
    tx_data = 8'hFF;
    clks(4);
    spi_xfer(8'hC3, 3, m0);
    clks(2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_miso", 32'(spi_if.o_miso), 32'd0);
    check("rst_mid_rx_data", 32'(rx_data), 32'h00);
    check("rst_mid_busy", 32'(busy), 32'd0);
    clks(2);
    rst_n = 1'b1;
    snap();
    clks(2);
    spi_xfer(8'hFF, 8, m0);
    clks(4);
    check("rst_cs_low_no_rx", 32'(n_rx - s_rx), 32'd0);
    check("rst_cs_low_no_start", 32'(n_start - s_start), 32'd0);
    check("rst_cs_low_busy", 32'(busy), 32'd0);
`ifdef FT_SPI_BYTECNT_EN
    check("rst_byte_count", 32'(byte_count), 32'd0);
`endif
    spi_if.i_cs_n = 1'b1;
    clks(6);
    frame_1byte(8'h5A, m0);
    clks(6);
    check("rst_next_frame_rx", 32'(rx_data), 32'h5A);
    check("rst_next_frame_cnt", 32'(n_rx - s_rx), 32'd1);

    // idle noise
    snap();
    noise_bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      spi_if.i_sck = ~spi_if.i_sck;
      clks(4);
      if (spi_if.o_miso !== 1'b0 || busy !== 1'b0) noise_bad = 1'b1;
    end
    clks(4);
    check("idle_miso_busy", 32'(noise_bad), 32'd0);
    check("idle_pulses", 32'((n_rx - s_rx) + (n_txn - s_txn) + (n_start - s_start)
                             + (n_end - s_end) + (n_err - s_err)), 32'd0);
    check("idle_rx_data", 32'(rx_data), 32'h5A);

    // two frames separated by minimum CS-high time
    snap();
    spi_if.i_cs_n = 1'b0;
    clks(4);
    spi_xfer(8'h55, 8, m0);
    clks(4);
    spi_if.i_cs_n = 1'b1;
    clks(SYNC + 2);
    spi_if.i_cs_n = 1'b0;
    clks(4);
    spi_xfer(8'hAA, 8, m1);
    clks(4);
    spi_if.i_cs_n = 1'b1;
    clks(6);
    check("spacing_start_cnt", 32'(n_start - s_start), 32'd2);
    check("spacing_end_cnt", 32'(n_end - s_end), 32'd2);
    check("spacing_rx_cnt", 32'(n_rx - s_rx), 32'd2);
    check("spacing_rx0", 32'(rx_log[s_rx]), 32'h55);
    check("spacing_rx1", 32'(rx_log[s_rx+1]), 32'hAA);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ft_spi_slave.md
Name: ft_spi_slave

Overview:
- SPI responder (slave) for the FT2232 host link (FT_SCK/FT_MOSI/FT_MISO/FT_CS). It is the counterpart of the flash-side SPI master.
- Oversamples the asynchronous host SPI signals on the internal clock, deserialises MOSI into bytes and serialises a supplied byte onto MISO.
- Feeds the ROM-programming path that writes a 6809 ROM image into the SPI flash.
- Mode 0 (CPOL=0, CPHA=0), MSB first, CS active low.

Parameters:
DATA_W, 8, bits per transfer word
SYNC_STAGES, 2, flip-flop stages per asynchronous input (minimum 2)

Ports:
clk  input  1  system clock (internal oscillator, 133 MHz nominal)
rst_n  input  1  asynchronous active-low reset
i_sck  input  1  host SPI clock, asynchronous
i_mosi  input  1  host serial data in, asynchronous
i_cs_n  input  1  host chip select, active low, asynchronous
o_miso  output  1  serial data to host
i_tx_data  input  DATA_W  next word to transmit; must be stable at the load points
o_tx_next  output  1  1-cycle pulse: i_tx_data has just been latched
o_rx_data  output  DATA_W  last complete received word; held until the next word completes
o_rx_valid  output  1  1-cycle pulse: o_rx_data has been updated
o_frame_start  output  1  1-cycle pulse on synchronised CS assertion
o_frame_end  output  1  1-cycle pulse on synchronised CS deassertion
o_frame_err  output  1  1-cycle pulse with o_frame_end if CS deasserted mid-word
o_busy  output  1  high while the frame is active

Behaviour:
- Reset values: o_miso=0, o_rx_data=0, o_busy=0, all pulse outputs 0. Internally, the shift registers and bit counter are 0 and the state is IDLE.
- Synchronisers:
  - i_sck, i_mosi and i_cs_n each pass through SYNC_STAGES flops; reset values are sck=0, mosi=0, cs_n=1.
  - One further registered copy of sck and cs_n is used for edge detection.
  - Edge latency from pin to internal event is SYNC_STAGES+1 clk.
- Supported SCK: up to clk/8. Faster SCK is not supported, and the bench must not drive it.
- FSM IDLE:
  - On a synchronised cs_n falling edge: latch i_tx_data into tx_shift, pulse o_tx_next and o_frame_start, clear bit_cnt, go to ACTIVE.
  - o_busy=1 from the cycle after the edge.
- FSM ACTIVE:
  - o_miso = tx_shift[DATA_W-1] continuously, so the MSB is valid before the first SCK rise.
  - SCK rising edge: rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt++.
  - SCK rising edge when bit_cnt == DATA_W-1 (word complete), all in the same cycle:
    - o_rx_data <= the completed word, pulse o_rx_valid;
    - bit_cnt <= 0;
    - tx_shift <= i_tx_data, pulse o_tx_next;
    - set skip_fall.
  - SCK falling edge:
    - if skip_fall: clear skip_fall and do not shift, so the newly loaded MSB is not lost;
    - else: tx_shift <= tx_shift << 1.
  - Synchronised cs_n rising edge: pulse o_frame_end, go to IDLE, o_busy=0.
    - If bit_cnt != 0, also pulse o_frame_err and discard the partial word (o_rx_data unchanged, no o_rx_valid).
- IDLE: o_miso=0, SCK edges are ignored, and rx_shift is not updated.
- Simultaneous events in one clk:
  - CS rise and an SCK rise: the CS rise wins and the SCK edge is ignored.
  - CS fall and an SCK rise: the CS fall is processed, and the SCK rise is processed only if it is detected on a later cycle.
- Reset mid-frame: everything returns to reset values immediately (asynchronous assert). Deassert is synchronous to clk.
  - After reset, a cs_n already low does not start a frame; the next falling edge is required.
- Back-to-back frames: CS high for at least SYNC_STAGES+2 clk must be recognised as a separate frame.

Optional Feature:
- Macro FT_SPI_BYTECNT_EN.
- Defined:
  - Adds output o_byte_count [15:0].
  - Cleared to 0 on o_frame_start; incremented with each o_rx_valid; saturates at 16'hFFFF.
  - Held after o_frame_end until the next frame starts. Reset value 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single byte: SCK=clk/8, CS low, MOSI=8'hA5, i_tx_data=8'h3C -> host samples MISO=8'h3C; one o_rx_valid with o_rx_data=8'hA5; one o_tx_next at CS fall and one at word end; o_frame_start and o_frame_end each pulse once, o_frame_err=0.
- Burst: 4 bytes 01,02,03,04 in one frame, i_tx_data updated after each o_tx_next to 10,20,30,40 -> MISO carries 10,20,30,40 with no dropped MSB; four o_rx_valid pulses in order; o_byte_count=4 with FT_SPI_BYTECNT_EN.
- Abort: CS deasserted after 5 SCK rises -> o_frame_err and o_frame_end pulse together; o_rx_data keeps the previous value; no o_rx_valid; the next frame receives 8'hFF correctly.
- Reset mid-frame: rst_n low after 3 bits, then released with CS still low -> all outputs 0; clocking 8 more SCK produces no o_rx_valid until CS goes high and then low again.
- Idle noise: SCK toggled 16 times with CS high -> no pulses, o_busy=0, o_miso=0.
- Frame spacing: two 1-byte frames (55, AA) with CS high for exactly SYNC_STAGES+2 clk -> two start/end pairs, o_rx_data sequence 55 then AA.
